// File: rtl/zube_wb_pkg.sv
// zube_wb_pkg: shared bus widths and FSM state type for the Wishbone initiator
package zube_wb_pkg;
    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;
    typedef enum logic [1:0] {IDLE, BUS, RESP} wb_init_state_t;
endpackage

// File: rtl/zube_timeout_counter.sv
// zube_timeout_counter: saturating cycle counter that flags the LIMIT-th enabled cycle (LIMIT=0 never expires)
// Ports: clk, rst (async, active-high), clear (sync zero), enable (count this cycle), expired (count==LIMIT-1 while enabled)
module zube_timeout_counter #(
    parameter int LIMIT = 255,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'((LIMIT == 0) ? 0 : LIMIT - 1);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable && cnt != '1) cnt <= cnt + CNT_W'(1);
    end
    assign expired = (LIMIT != 0) && enable && (cnt == LAST);
endmodule

// File: rtl/zube_wb_initiator.sv
// zube_wb_initiator: single-outstanding Wishbone classic master driven by a valid/ready command port
// Ports: wb_clk_i/wb_rst_i (async active-high); cmd_* command in; rsp_* response out; wbm_* Wishbone master
module zube_wb_initiator import zube_wb_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [WB_ADDR_W-1:0] cmd_addr_i,
    input  logic [WB_DATA_W-1:0] cmd_data_i,
    input  logic [WB_SEL_W-1:0]  cmd_sel_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [WB_DATA_W-1:0] rsp_data_o,
    output logic                 rsp_err_o,
    output logic                 rsp_timeout_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [WB_SEL_W-1:0]  wbm_sel_o,
    output logic [WB_ADDR_W-1:0] wbm_adr_o,
    output logic [WB_DATA_W-1:0] wbm_dat_o,
    input  logic [WB_DATA_W-1:0] wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i
);
    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    wb_init_state_t state, state_n;
    logic expired, stb_n, we_n, rsp_valid_n, rsp_err_n, rsp_to_n;
    logic [WB_SEL_W-1:0]  sel_n;
    logic [WB_ADDR_W-1:0] adr_n;
    logic [WB_DATA_W-1:0] dat_n, rsp_data_n;

    zube_timeout_counter #(.LIMIT(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_timeout (
        .clk(wb_clk_i),
        .rst(wb_rst_i),
        .clear(state != BUS),
        .enable(state == BUS),
        .expired(expired)
    );

    assign cmd_ready_o = (state == IDLE) && !wb_rst_i;
    assign wbm_cyc_o   = wbm_stb_o;

    always_comb begin
        state_n     = state;
        stb_n       = wbm_stb_o;
        we_n        = wbm_we_o;
        sel_n       = wbm_sel_o;
        adr_n       = wbm_adr_o;
        dat_n       = wbm_dat_o;
        rsp_valid_n = rsp_valid_o;
        rsp_err_n   = rsp_err_o;
        rsp_to_n    = rsp_timeout_o;
        rsp_data_n  = rsp_data_o;
        case (state)
            IDLE: if (cmd_valid_i && cmd_ready_o) begin
                we_n    = cmd_we_i;
                sel_n   = cmd_sel_i;
                adr_n   = cmd_addr_i;
                dat_n   = cmd_data_i;
                stb_n   = 1'b1;
                state_n = BUS;
            end
            // ERR outranks ACK, and either outranks a timeout landing on the same edge
            BUS: if (wbm_err_i || wbm_ack_i || expired) begin
                stb_n       = 1'b0;
                rsp_valid_n = 1'b1;
                rsp_err_n   = wbm_err_i || !wbm_ack_i;
                rsp_to_n    = !wbm_err_i && !wbm_ack_i;
                rsp_data_n  = (!wbm_err_i && wbm_ack_i && !wbm_we_o) ? wbm_dat_i : '0;
                state_n     = RESP;
            end
            RESP: if (rsp_ready_i) begin
                rsp_valid_n = 1'b0;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            wbm_stb_o     <= 1'b0;
            wbm_we_o      <= 1'b0;
            wbm_sel_o     <= '0;
            wbm_adr_o     <= '0;
            wbm_dat_o     <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            rsp_data_o    <= '0;
        end else begin
            state         <= state_n;
            wbm_stb_o     <= stb_n;
            wbm_we_o      <= we_n;
            wbm_sel_o     <= sel_n;
            wbm_adr_o     <= adr_n;
            wbm_dat_o     <= dat_n;
            rsp_valid_o   <= rsp_valid_n;
            rsp_err_o     <= rsp_err_n;
            rsp_timeout_o <= rsp_to_n;
            rsp_data_o    <= rsp_data_n;
        end
    end
endmodule

// File: tb/tb_zube_wb_initiator.sv
// tb_zube_wb_initiator: scoreboard bench for zube_wb_initiator with a scripted Wishbone slave
module tb_zube_wb_initiator;
    logic        clk = 0, rst = 1;
    logic        cmd_valid = 0, cmd_we = 0, rsp_ready = 0;
    logic [31:0] cmd_addr = 0, cmd_data = 0;
    logic [3:0]  cmd_sel = 0;
    logic        cmd_ready, rsp_valid, rsp_err, rsp_to;
    logic [31:0] rsp_data;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o;
    logic [31:0] dat_i = 0;
    logic        ack = 0, err = 0;

    zube_wb_initiator #(.TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_to),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i),
        .wbm_ack_i(ack), .wbm_err_i(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        to;
        int          lat;
        int          slen;
    } exp_t;
    exp_t sb[$];

    int checks = 0, errors = 0;
    int cyc_no = 0, acc_cyc = 0, vcyc = 0, run_len = 0, last_len = 0, idx = 0;
    int s_mode = 0, s_wait = 0;
    logic s_force = 0, prev_v = 0;
    logic        cur_we = 0;
    logic [3:0]  cur_sel = 0;
    logic [31:0] cur_adr = 0, cur_dat = 0, s_rdata = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc_no <= cyc_no + 1;

    // slave model (modes: 0 ack, 1 err, 2 ack+err, 3 silent) and scoreboard monitor
    always @(negedge clk) begin
        idx = run_len;
        if (stb) begin
            chk("bus_adr", adr, cur_adr);
            chk("bus_dat", dat_o, cur_dat);
            chk("bus_we_sel", {27'd0, we, sel}, {27'd0, cur_we, cur_sel});
            chk("bus_cyc", {31'd0, cyc}, 32'd1);
            run_len++;
        end else begin
            if (run_len != 0) last_len = run_len;
            run_len = 0;
        end
        ack   = s_force || (stb && (s_mode == 0 || s_mode == 2) && idx == s_wait);
        err   = stb && (s_mode == 1 || s_mode == 2) && idx == s_wait;
        dat_i = s_rdata;
        if (rsp_valid && !prev_v) vcyc = cyc_no;
        prev_v = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual=1 required=0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                chk("rsp_timeout", {31'd0, rsp_to}, {31'd0, e.to});
                chk("rsp_latency", vcyc - acc_cyc, e.lat);
                chk("stb_len", last_len, e.slen);
            end
        end
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int mode, input int waits, input logic [31:0] rd);
        s_mode = mode; s_wait = waits; s_rdata = rd;
        cur_we = w; cur_adr = a; cur_dat = d; cur_sel = s;
        cmd_we = w; cmd_addr = a; cmd_data = d; cmd_sel = s; cmd_valid = 1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc_cyc = cyc_no + 1;
                break;
            end
            if (n == 49) begin
                $display("FAIL accept_wait actual=timeout required=accept");
                $fatal(1, "command never accepted");
            end
        end
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int mode, input int waits, input logic [31:0] rd,
                        input logic [31:0] ed, input logic ee, input logic et, input int lat, input int slen,
                        input int hold);
        exp_t e;
        e.data = ed; e.err = ee; e.to = et; e.lat = lat; e.slen = slen;
        sb.push_back(e);
        issue(w, a, d, s, mode, waits, rd);
        for (int n = 0; n < 100 && !rsp_valid; n++) begin
            @(posedge clk); #1;
        end
        if (!rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_wait actual=no_valid required=valid");
            void'(sb.pop_back());
        end else begin
            repeat (hold) begin
                chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
                chk("hold_stb", {31'd0, stb}, 32'd0);
                @(posedge clk); #1;
            end
            rsp_ready = 1;
            @(posedge clk); #1;
            rsp_ready = 0;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_cyc_stb", {30'd0, cyc, stb}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_adr", adr, 32'd0);
        rst = 0;
        #1 chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        // zero-wait write
        send(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0, 32'h0, 0, 0, 1, 1, 0);
        // read with 3 wait states
        send(0, 32'h4, 32'h0, 4'hF, 0, 3, 32'h12345678, 32'h12345678, 0, 0, 4, 4, 0);
        // silent slave -> timeout after 8 STB cycles
        send(0, 32'h8, 32'h0, 4'h3, 3, 0, 32'hAAAA5555, 32'h0, 1, 1, 8, 8, 0);
        s_force = 1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("late_ack_cyc", {31'd0, cyc}, 32'd0);
            chk("late_ack_valid", {31'd0, rsp_valid}, 32'd0);
            chk("late_ack_ready", {31'd0, cmd_ready}, 32'd1);
        end
        s_force = 0;
        @(posedge clk); #1;
        // ACK and ERR together
        send(0, 32'hC, 32'h0, 4'hF, 2, 0, 32'hCAFEF00D, 32'h0, 1, 0, 1, 1, 0);
        // ACK on the expiry cycle wins over timeout
        send(0, 32'h14, 32'h0, 4'hF, 0, 7, 32'h0BADF00D, 32'h0BADF00D, 0, 0, 8, 8, 0);
        // ERR on write after 2 waits
        send(1, 32'h18, 32'h55AA55AA, 4'h1, 1, 2, 32'h0, 32'h0, 1, 0, 3, 3, 0);
        // back-to-back with response back-pressure on the first
        send(1, 32'h20, 32'h01020304, 4'hC, 0, 0, 32'h0, 32'h0, 0, 0, 1, 1, 5);
        chk("b2b_ready_next", {31'd0, cmd_ready}, 32'd1);
        send(0, 32'h24, 32'h0, 4'hF, 0, 1, 32'h89ABCDEF, 32'h89ABCDEF, 0, 0, 2, 2, 0);
        // reset while the bus cycle is in flight
        issue(0, 32'h28, 32'h0, 4'hF, 3, 0, 32'h0);
        @(posedge clk); #1;
        chk("mid_bus_stb", {31'd0, stb}, 32'd1);
        rst = 1;
        #1;
        chk("async_cyc_stb", {30'd0, cyc, stb}, 32'd0);
        chk("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        #1 chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_rsp_after_rst", {31'd0, rsp_valid}, 32'd0);
        end
        send(0, 32'h2C, 32'h0, 4'hF, 0, 0, 32'hFEEDFACE, 32'hFEEDFACE, 0, 0, 1, 1, 0);
        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
